generic_bus_mem_responder: RTL and testbench
============================================

Name: generic_bus_mem_responder

Overview:
- Responder (target) end of the generic_bus_if protocol, i.e. what the memory controller's out_gen_bus_if drives into: a word-organised RAM behind a wait-state engine.
- Serves as the backing memory for cache/coherence/memory-controller integration benches and as the on-chip scratch RAM in small configurations.
- Accepts one read or write at a time, inserts configurable latency plus optional injected stalls, then completes with a single-cycle busy-low pulse.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- DEPTH, 1024, number of 32-bit words (power of two, >= 2).
- LATENCY, 2, wait cycles inserted between request capture and completion (0..255).
- ERR_RDATA, 32'hBAD1_BAD1, read data returned for out-of-range addresses.

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- addr  in  32  byte address from the requester.
- wdata  in  32  write data.
- byte_en  in  4  byte lane enables; bit i selects bits 8i+7:8i.
- ren  in  1  read request, held until completion.
- wen  in  1  write request, held until completion.
- rdata  out  32  read data, valid only in the completion cycle.
- busy  out  1  0 only in the completion cycle, otherwise 1.
- stall_inj  in  1  verification hook; while 1, the wait counter freezes.
- range_err  out  1  sticky flag: an out-of-range access has occurred.
- req_count  out  16  number of completed transfers, wraps at 2^16.

Behaviour:
- Reset (async, nRST=0): state=IDLE, busy=1, rdata=0, range_err=0, req_count=0, counter=0. RAM contents are not reset.
- The state machine has three states: IDLE, WAIT and DONE.
- IDLE:
  - If (ren|wen)=1, latch addr, wdata, byte_en and op (write if wen=1, else read; wen wins when both are set).
  - Load counter=LATENCY, then go to WAIT, or straight to DONE when LATENCY=0.
- WAIT:
  - If ren=0 and wen=0 (abort), go to IDLE: no write committed, busy stays 1, req_count unchanged.
  - Else if stall_inj=1, hold the counter.
  - Else if counter=1, go to DONE; otherwise decrement the counter.
- DONE (one cycle):
  - busy=0.
  - Read: rdata = RAM[index], or ERR_RDATA if out of range.
  - Write: RAM[index] updated per byte_en at the clock edge ending this cycle, with unselected bytes preserved.
  - req_count increments; go to IDLE unconditionally.
  - Requests are not sampled in DONE, so the held request is not re-accepted.
- Latency: a request first sampled in IDLE at cycle T produces busy=0 at cycle T+1+LATENCY+S, where S is the number of WAIT cycles with stall_inj=1.
  - Back-to-back: the next request can be accepted at T+2+LATENCY+S at the earliest.
- Address map: index = (addr - BASE_ADDR) >> 2, in 32-bit unsigned arithmetic.
  - An address is in range iff addr >= BASE_ADDR and addr < BASE_ADDR + 4*DEPTH.
  - addr[1:0] is ignored; byte_en selects the lanes.
- Out of range: range_err is set in the DONE cycle and stays set until reset.
  - Writes are dropped.
  - Reads return ERR_RDATA.
- rdata outside the DONE cycle holds its last value. Requesters must not sample it then.
- Latched values are used throughout; changes to addr, wdata or byte_en during WAIT are ignored.
- byte_en=0 on a write completes normally and modifies nothing.
- Reset asserted mid-WAIT or in DONE: return to IDLE immediately. A write whose DONE edge is not reached is not committed.
- Implementation: the RAM is an inferred synchronous-write array. The read path may be combinational from the latched index.

Test Plan:
- LATENCY=2: write 32'hDEAD_BEEF with byte_en=4'hF at BASE_ADDR+8, then read it back.
  - Each transfer has busy=0 exactly 3 cycles after the request is sampled.
  - Read rdata=32'hDEAD_BEEF; req_count=2.
- Over the word from the first test, write 32'h0000_1200 with byte_en=4'b0010, then read.
  - rdata=32'hDEAD_12EF.
- Hold stall_inj=1 for 4 cycles during WAIT of a read.
  - busy=0 at T+7 (LATENCY=2); no extra req_count increment.
- Drop wen after 1 WAIT cycle of a write of 32'h1111_1111 to BASE_ADDR+8.
  - busy never goes 0; a subsequent read returns the prior value; req_count unchanged.
- Read at BASE_ADDR+4*DEPTH, and at BASE_ADDR-4.
  - rdata=32'hBAD1_BAD1 and range_err=1 after the first; range_err remains 1.
  - A write there leaves all in-range words unchanged.
- LATENCY=0 build: issue back-to-back reads with ren held high continuously across both.
  - busy=0 at T+1 and T+3, never on consecutive cycles.
  - Pulsing nRST low mid-transfer returns busy=1 and req_count=0.

Source files
------------

// File: rtl/generic_bus_mem_responder.sv
// Responder end of the generic bus: word-organised RAM behind a wait-state engine.
// One transfer at a time; completion is signalled by a single-cycle busy-low pulse.
module generic_bus_mem_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] ERR_RDATA = 32'hBAD1_BAD1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byte_en,
    input  logic        ren,
    input  logic        wen,
    output logic [31:0] rdata,
    output logic        busy,
    input  logic        stall_inj,
    output logic        range_err,
    output logic [15:0] req_count
);

    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = 8;
    localparam logic [32:0] END_ADDR = 33'(BASE_ADDR) + 33'(DEPTH) * 33'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // 33-bit upper compare so a map ending at 2^32 still works
    function automatic logic in_range(input logic [31:0] a);
        return (a >= BASE_ADDR) && (33'(a) < END_ADDR);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    logic [31:0] mem [DEPTH];

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              write_q, write_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              range_err_q, range_err_d;
    logic [15:0]       req_count_q, req_count_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        write_d     = write_q;
        rdata_d     = rdata_q;
        range_err_d = range_err_q;
        req_count_d = req_count_q;

        case (state_q)
            S_IDLE: begin
                if (ren || wen) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    be_d    = byte_en;
                    write_d = wen;
                    cnt_d   = CNT_W'(LATENCY);
                    state_d = (LATENCY == 0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!ren && !wen) begin
                    state_d = S_IDLE;
                end else if (stall_inj) begin
                    cnt_d = cnt_q;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are prepared on entry to DONE
        busy_d = (state_d != S_DONE);
        if (state_d == S_DONE) begin
            req_count_d = req_count_q + 16'd1;
            if (!in_range(addr_d)) begin
                range_err_d = 1'b1;
            end
            if (!write_d) begin
                rdata_d = in_range(addr_d) ? mem[word_idx(addr_d)] : ERR_RDATA;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            write_q     <= 1'b0;
            rdata_q     <= '0;
            busy_q      <= 1'b1;
            range_err_q <= 1'b0;
            req_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            write_q     <= write_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            range_err_q <= range_err_d;
            req_count_q <= req_count_d;
        end
    end

    // Write commits on the edge that ends DONE; out-of-range writes are dropped
    always_ff @(posedge CLK) begin
        if (state_q == S_DONE && write_q && in_range(addr_q)) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[word_idx(addr_q)][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign range_err = range_err_q;
    assign req_count = req_count_q;

endmodule

// File: tb/tb_generic_bus_mem_responder.sv
// Directed bench: LATENCY=2 instance for data/latency/stall/abort/range cases,
// LATENCY=0 instance for back-to-back completion and reset mid-transfer.
module tb_generic_bus_mem_responder;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] ERRD = 32'hBAD1_BAD1;

    logic        CLK;
    logic        rst_a_n, rst_b_n;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic [3:0]  be_a;
    logic        ren_a, wen_a, busy_a, stall_a, range_err_a;
    logic [15:0] req_count_a;
    logic [31:0] addr_b, wdata_b, rdata_b;
    logic [3:0]  be_b;
    logic        ren_b, wen_b, busy_b, stall_b, range_err_b;
    logic [15:0] req_count_b;

    int checks = 0;
    int errors = 0;

    generic_bus_mem_responder u_dut_a (
        .CLK(CLK), .nRST(rst_a_n), .addr(addr_a), .wdata(wdata_a), .byte_en(be_a),
        .ren(ren_a), .wen(wen_a), .rdata(rdata_a), .busy(busy_a),
        .stall_inj(stall_a), .range_err(range_err_a), .req_count(req_count_a)
    );

    generic_bus_mem_responder #(.LATENCY(0)) u_dut_b (
        .CLK(CLK), .nRST(rst_b_n), .addr(addr_b), .wdata(wdata_b), .byte_en(be_b),
        .ren(ren_b), .wen(wen_b), .rdata(rdata_b), .busy(busy_b),
        .stall_inj(stall_b), .range_err(range_err_b), .req_count(req_count_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transfer on instance A; cyc = clock edges from request until busy is seen low
    task automatic xfer_a(input logic is_wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, input int stall_len,
                          output int cyc, output logic [31:0] rd,
                          output logic [15:0] cnt, output logic rerr);
        cyc = 0;
        @(negedge CLK);
        addr_a = a; wdata_a = d; be_a = be; wen_a = is_wr; ren_a = !is_wr;
        do begin
            @(posedge CLK);
            cyc++;
            @(negedge CLK);
            if (stall_len > 0 && cyc == 1) stall_a = 1'b1;
            if (stall_len > 0 && cyc == 1 + stall_len) stall_a = 1'b0;
        end while (busy_a && cyc < 50);
        rd   = rdata_a;
        cnt  = req_count_a;
        rerr = range_err_a;
        ren_a = 1'b0; wen_a = 1'b0; stall_a = 1'b0;
    endtask

    int          cyc;
    logic [31:0] rd;
    logic [15:0] cnt;
    logic        rerr;
    logic [15:0] exp_cnt;
    logic        saw_done;
    logic [3:0]  bsy;
    logic [31:0] rd0, rd2;

    initial begin
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        addr_a = '0; wdata_a = '0; be_a = '0; ren_a = 1'b0; wen_a = 1'b0; stall_a = 1'b0;
        addr_b = '0; wdata_b = '0; be_b = '0; ren_b = 1'b0; wen_b = 1'b0; stall_b = 1'b0;
        exp_cnt = '0;
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_busy_a", 32'(busy_a), 32'd1);
        chk("rst_rdata_a", rdata_a, 32'd0);
        chk("rst_rerr_a", 32'(range_err_a), 32'd0);
        chk("rst_cnt_a", 32'(req_count_a), 32'd0);
        chk("rst_busy_b", 32'(busy_b), 32'd1);
        chk("rst_cnt_b", 32'(req_count_b), 32'd0);
        rst_a_n = 1'b1; rst_b_n = 1'b1;

        // Full-word write then read back
        xfer_a(1'b1, BASE + 32'd8, 32'hDEAD_BEEF, 4'hF, 0, cyc, rd, cnt, rerr);
        exp_cnt++;
        chk("wr1_lat", 32'(cyc), 32'd3);
        chk("wr1_cnt", 32'(cnt), 32'(exp_cnt));
        xfer_a(1'b0, BASE + 32'd8, 32'h0, 4'h0, 0, cyc, rd, cnt, rerr);
        exp_cnt++;
        chk("rd1_lat", 32'(cyc), 32'd3);
        chk("rd1_data", rd, 32'hDEAD_BEEF);
        chk("rd1_cnt", 32'(cnt), 32'd2);

        // Single-lane write
        xfer_a(1'b1, BASE + 32'd8, 32'h0000_1200, 4'b0010, 0, cyc, rd, cnt, rerr);
        exp_cnt++;
        chk("wr2_lat", 32'(cyc), 32'd3);
        xfer_a(1'b0, BASE + 32'd8, 32'h0, 4'h0, 0, cyc, rd, cnt, rerr);
        exp_cnt++;
        chk("rd2_data", rd, 32'hDEAD_12EF);

        // Four stalled WAIT cycles stretch latency to 7
        xfer_a(1'b0, BASE + 32'd8, 32'h0, 4'h0, 4, cyc, rd, cnt, rerr);
        exp_cnt++;
        chk("stall_lat", 32'(cyc), 32'd7);
        chk("stall_data", rd, 32'hDEAD_12EF);
        chk("stall_cnt", 32'(cnt), 32'(exp_cnt));

        // Abort a write after one WAIT cycle
        saw_done = 1'b0;
        @(negedge CLK);
        addr_a = BASE + 32'd8; wdata_a = 32'h1111_1111; be_a = 4'hF; wen_a = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        if (!busy_a) saw_done = 1'b1;
        wen_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (!busy_a) saw_done = 1'b1;
        end
        chk("abort_busy", 32'(saw_done), 32'd0);
        chk("abort_cnt", 32'(req_count_a), 32'(exp_cnt));
        xfer_a(1'b0, BASE + 32'd8, 32'h0, 4'h0, 0, cyc, rd, cnt, rerr);
        exp_cnt++;
        chk("abort_rd", rd, 32'hDEAD_12EF);
        chk("abort_rd_cnt", 32'(cnt), 32'(exp_cnt));

        // byte_en=0 write completes but changes nothing
        xfer_a(1'b1, BASE + 32'd8, 32'hFFFF_FFFF, 4'h0, 0, cyc, rd, cnt, rerr);
        exp_cnt++;
        chk("be0_lat", 32'(cyc), 32'd3);
        xfer_a(1'b0, BASE + 32'd8, 32'h0, 4'h0, 0, cyc, rd, cnt, rerr);
        exp_cnt++;
        chk("be0_rd", rd, 32'hDEAD_12EF);

        // Edge words that a wrapped out-of-range index would hit
        xfer_a(1'b1, BASE, 32'h0123_4567, 4'hF, 0, cyc, rd, cnt, rerr);
        exp_cnt++;
        xfer_a(1'b1, BASE + 32'h0FFC, 32'h89AB_CDEF, 4'hF, 0, cyc, rd, cnt, rerr);
        exp_cnt++;
        chk("pre_rerr", 32'(rerr), 32'd0);

        // Out-of-range reads just past the top and just below the base
        xfer_a(1'b0, BASE + 32'h1000, 32'h0, 4'h0, 0, cyc, rd, cnt, rerr);
        exp_cnt++;
        chk("oor_hi_data", rd, ERRD);
        chk("oor_hi_rerr", 32'(rerr), 32'd1);
        xfer_a(1'b0, BASE - 32'd4, 32'h0, 4'h0, 0, cyc, rd, cnt, rerr);
        exp_cnt++;
        chk("oor_lo_data", rd, ERRD);
        chk("oor_lo_rerr", 32'(rerr), 32'd1);
        chk("oor_cnt", 32'(cnt), 32'(exp_cnt));

        // Out-of-range writes must be dropped
        xfer_a(1'b1, BASE + 32'h1000, 32'hFFFF_FFFF, 4'hF, 0, cyc, rd, cnt, rerr);
        exp_cnt++;
        xfer_a(1'b1, BASE - 32'd4, 32'hFFFF_FFFF, 4'hF, 0, cyc, rd, cnt, rerr);
        exp_cnt++;
        xfer_a(1'b0, BASE, 32'h0, 4'h0, 0, cyc, rd, cnt, rerr);
        exp_cnt++;
        chk("oor_w0", rd, 32'h0123_4567);
        xfer_a(1'b0, BASE + 32'h0FFC, 32'h0, 4'h0, 0, cyc, rd, cnt, rerr);
        exp_cnt++;
        chk("oor_w1023", rd, 32'h89AB_CDEF);
        xfer_a(1'b0, BASE + 32'd8, 32'h0, 4'h0, 0, cyc, rd, cnt, rerr);
        exp_cnt++;
        chk("oor_w2", rd, 32'hDEAD_12EF);
        chk("sticky_rerr", 32'(rerr), 32'd1);
        chk("oor_final_cnt", 32'(cnt), 32'(exp_cnt));

        // Reset mid-WAIT of a write: nothing committed, counters cleared
        @(negedge CLK);
        addr_a = BASE + 32'd8; wdata_a = 32'h7777_7777; be_a = 4'hF; wen_a = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        rst_a_n = 1'b0;
        wen_a = 1'b0;
        #1;
        chk("rstw_busy", 32'(busy_a), 32'd1);
        chk("rstw_cnt", 32'(req_count_a), 32'd0);
        chk("rstw_rerr", 32'(range_err_a), 32'd0);
        @(negedge CLK);
        rst_a_n = 1'b1;
        xfer_a(1'b0, BASE + 32'd8, 32'h0, 4'h0, 0, cyc, rd, cnt, rerr);
        chk("rstw_rd", rd, 32'hDEAD_12EF);
        chk("rstw_rd_cnt", 32'(cnt), 32'd1);

        // LATENCY=0 instance: single write
        @(negedge CLK);
        addr_b = BASE + 32'd4; wdata_b = 32'h5A5A_C3C3; be_b = 4'hF; wen_b = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk("b_wr_busy", 32'(busy_b), 32'd0);
        wen_b = 1'b0;

        // Back-to-back reads with ren held continuously
        rd0 = '0; rd2 = '0;
        @(negedge CLK);
        ren_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge CLK);
            @(negedge CLK);
            bsy[k] = busy_b;
            if (k == 0) rd0 = rdata_b;
            if (k == 2) rd2 = rdata_b;
        end
        ren_b = 1'b0;
        chk("b_b2b_busy", 32'(bsy), 32'(4'b1010));
        chk("b_rd0", rd0, 32'h5A5A_C3C3);
        chk("b_rd2", rd2, 32'h5A5A_C3C3);
        chk("b_cnt", 32'(req_count_b), 32'd3);

        // Reset pulse in the DONE cycle
        @(negedge CLK);
        ren_b = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk("b_done_busy", 32'(busy_b), 32'd0);
        rst_b_n = 1'b0;
        #1;
        chk("b_rst_busy", 32'(busy_b), 32'd1);
        chk("b_rst_cnt", 32'(req_count_b), 32'd0);
        chk("b_rst_rerr", 32'(range_err_b), 32'd0);
        ren_b = 1'b0;
        @(negedge CLK);
        rst_b_n = 1'b1;
        @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
